// File: rtl/riscv_prefetch_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_prefetch_buf : sequential instruction prefetch FIFO with flush.   |
// | Optional macro PREFETCH_BYPASS_EN: zero-latency bypass when FIFO empty.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module riscv_prefetch_buf #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RSTADDR   = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            core_valid_o,
  input  logic            core_ready_i,
  output logic [XLEN-1:0] core_instr_o,
  output logic [XLEN-1:0] core_pc_o,
  input  logic            core_flush_i,
  input  logic [XLEN-1:0] core_flush_addr_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned       c_cnt_w     = $clog2(DEPTH + 1);
  localparam int unsigned       c_ptr_w     = $clog2(DEPTH);
  localparam int unsigned       c_tag_w     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [c_cnt_w:0]  c_depth     = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_max_outst = c_cnt_w'(MAX_OUTST);
  localparam logic [c_tag_w-1:0] c_tag_last  = c_tag_w'(MAX_OUTST - 1);

  logic [XLEN-1:0]    fifo_pc_q    [DEPTH];
  logic [XLEN-1:0]    fifo_pc_d    [DEPTH];
  logic [XLEN-1:0]    fifo_instr_q [DEPTH];
  logic [XLEN-1:0]    fifo_instr_d [DEPTH];
  logic [XLEN-1:0]    tag_q        [MAX_OUTST];
  logic [XLEN-1:0]    tag_d        [MAX_OUTST];
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [c_tag_w-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [c_cnt_w-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [XLEN-1:0]    fpc_q, fpc_d;

  logic             req_fire, rsp_ok, rsp_live, byp, pop, pop_fifo, push;
  logic [c_cnt_w:0] occ;
  logic             unused_flush_lsb;

  assign unused_flush_lsb = ^core_flush_addr_i[1:0];
  assign occ              = {1'b0, count_q} + {1'b0, outst_q};

  // Gated by rst_i so the bus sees no request while reset is held.
  assign mem_req_o  = !rst_i && !core_flush_i && (occ < c_depth) && (outst_q < c_max_outst);
  assign mem_addr_o = fpc_q;

  assign req_fire = mem_req_o && mem_gnt_i;
  assign rsp_ok   = mem_rvalid_i && (outst_q != '0);
  assign rsp_live = rsp_ok && (discard_q == '0) && !core_flush_i;

`ifdef PREFETCH_BYPASS_EN
  assign byp          = rsp_live && (count_q == '0);
  assign core_valid_o = (count_q != '0) || byp;
  assign core_instr_o = byp ? mem_rdata_i : fifo_instr_q[rd_ptr_q];
  assign core_pc_o    = byp ? tag_q[tag_rd_q] : fifo_pc_q[rd_ptr_q];
`else
  assign byp          = 1'b0;
  assign core_valid_o = (count_q != '0);
  assign core_instr_o = fifo_instr_q[rd_ptr_q];
  assign core_pc_o    = fifo_pc_q[rd_ptr_q];
`endif

  assign pop      = core_valid_o && core_ready_i && !core_flush_i;
  assign pop_fifo = pop && !byp;
  assign push     = rsp_live && !(byp && core_ready_i);

  always_comb begin
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    tag_d        = tag_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    tag_rd_d     = tag_rd_q;
    tag_wr_d     = tag_wr_q;
    fpc_d        = fpc_q;
    outst_d      = outst_q + c_cnt_w'(req_fire) - c_cnt_w'(rsp_ok);
    count_d      = count_q + c_cnt_w'(push) - c_cnt_w'(pop_fifo);
    discard_d    = discard_q - c_cnt_w'(rsp_ok && (discard_q != '0));

    if (req_fire) begin
      tag_d[tag_wr_q] = fpc_q;
      tag_wr_d        = (tag_wr_q == c_tag_last) ? '0 : tag_wr_q + c_tag_w'(1);
      fpc_d           = fpc_q + XLEN'(4);
    end
    if (rsp_ok) begin
      tag_rd_d = (tag_rd_q == c_tag_last) ? '0 : tag_rd_q + c_tag_w'(1);
    end
    if (push) begin
      fifo_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
      fifo_instr_d[wr_ptr_q] = mem_rdata_i;
      wr_ptr_d               = wr_ptr_q + c_ptr_w'(1);
    end
    if (pop_fifo) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end

    // Every request still in flight after this cycle belongs to the old stream.
    if (core_flush_i) begin
      count_d   = '0;
      rd_ptr_d  = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      discard_d = outst_d;
      fpc_d     = {core_flush_addr_i[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
      tag_q        <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      tag_rd_q     <= '0;
      tag_wr_q     <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      fpc_q        <= RSTADDR;
    end else begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      tag_q        <= tag_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      tag_rd_q     <= tag_rd_d;
      tag_wr_q     <= tag_wr_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      fpc_q        <= fpc_d;
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> (outst_q != '0));
  a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i) occ <= c_depth);
  a_discard: assert property (@(posedge clk_i) disable iff (rst_i) discard_q <= outst_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_prefetch_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_prefetch_buf : randomized scoreboard bench for the prefetcher. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_riscv_prefetch_buf;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RSTADDR   = 32'h0000_0100;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_valid_o, core_ready_i = 1'b0, core_flush_i = 1'b0;
  logic [31:0] core_instr_o, core_pc_o, core_flush_addr_i = '0;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = '0;

  always #5 clk = ~clk;

  riscv_prefetch_buf #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RSTADDR(RSTADDR)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_instr_o(core_instr_o), .core_pc_o(core_pc_o),
    .core_flush_i(core_flush_i), .core_flush_addr_i(core_flush_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct { logic [31:0] addr; int unsigned epoch; longint due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;

  req_t        pend[$];
  item_t       exp_q[$];
  int          n_checks = 0, n_fail = 0;
  longint      cyc = 0, last_due = 0;
  int unsigned epoch = 0;
  logic [31:0] exp_fpc = RSTADDR;
  int          n_grants = 0, n_deliv = 0, n_start = 0;
  logic        live_into_empty = 1'b0, saw_wrap = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  int          gnt_pct = 100, rdy_pct = 100, dly_min = 1, dly_max = 1, flush_pct = 0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_tgt = '0;

  // Memory image: an arbitrary scramble of the word address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Drives one cycle of stimulus just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    core_ready_i = ($urandom_range(99) < rdy_pct);
    mem_gnt_i    = ($urandom_range(99) < gnt_pct);
    core_flush_i = 1'b0;
    if (flush_req) begin
      core_flush_i      = 1'b1;
      core_flush_addr_i = flush_tgt;
      flush_req         = 1'b0;
    end else if (flush_pct > 0 && $urandom_range(99) < flush_pct) begin
      core_flush_i      = 1'b1;
      core_flush_addr_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = img(pend[0].addr);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_ready_i = 1'b0; core_flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_core_valid", core_valid_o, 0);
    check_eq("rst_core_instr", core_instr_o, 0);
    check_eq("rst_core_pc", core_pc_o, 0);
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, RSTADDR);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bus/reference model: issues expectations as the stream is produced.
  always @(negedge clk) begin
    req_t r;
    int   d;
    if (rst) begin
      pend.delete(); exp_q.delete();
      exp_fpc = RSTADDR; epoch++; last_due = 0;
      n_start = 0; live_into_empty = 1'b0; prev_wait = 1'b0;
    end else begin
      n_start = exp_q.size();
      check_eq("occupancy_le_depth", (pend.size() + exp_q.size()) <= DEPTH, 1);
      check_eq("outst_le_max", pend.size() <= MAX_OUTST, 1);
      if (prev_wait && !core_flush_i) begin
        check_eq("req_held", mem_req_o, 1);
        check_eq("addr_held", mem_addr_o, prev_addr);
      end
      live_into_empty = 1'b0;
      if (mem_rvalid_i && pend.size() > 0) begin
        r = pend.pop_front();
        if (r.epoch == epoch && !core_flush_i) begin
          exp_q.push_back('{pc: r.addr, instr: img(r.addr)});
          if (n_start == 0) live_into_empty = 1'b1;
        end
      end
      if (mem_req_o && mem_gnt_i) begin
        check_eq("fetch_addr", mem_addr_o, exp_fpc);
        d = $urandom_range(dly_max, dly_min);
        r.addr  = exp_fpc;
        r.epoch = epoch;
        r.due   = (cyc + d > last_due) ? cyc + d : last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        exp_fpc += 32'd4;
        n_grants++;
      end
      prev_wait = mem_req_o && !mem_gnt_i;
      prev_addr = mem_addr_o;
      if (core_flush_i) begin
        epoch++;
        exp_q.delete();
        exp_fpc = {core_flush_addr_i[31:2], 2'b00};
      end
    end
  end

  // Monitor: compares the core-side stream against the expectation queue.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check_eq("core_valid", core_valid_o, (n_start > 0) || (BYP && live_into_empty));
      if (core_valid_o && exp_q.size() > 0) begin
        check_eq("core_pc", core_pc_o, exp_q[0].pc);
        check_eq("core_instr", core_instr_o, exp_q[0].instr);
      end
      if (core_valid_o && core_ready_i && !core_flush_i) begin
        check_eq("pop_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (exp_q[0].pc == 32'h0 && n_deliv > 0) saw_wrap = 1'b1;
          void'(exp_q.pop_front());
          n_deliv++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0, d0;
    bit done;

    // Streaming from reset address with an always-granting memory.
    do_reset();
    d0 = n_deliv;
    repeat (30) step();
    check_eq("stream_deliveries", n_deliv - d0 >= 20, 1);

    // Back-pressure: exactly DEPTH fetches fill the buffer.
    do_reset();
    rdy_pct = 0;
    g0 = n_grants;
    repeat (20) step();
    #2;
    check_eq("bp_grants", n_grants - g0, DEPTH);
    check_eq("bp_req_low", mem_req_o, 0);
    check_eq("bp_valid", core_valid_o, 1);
    check_eq("bp_head_pc", core_pc_o, RSTADDR);
    rdy_pct = 100;
    d0 = n_deliv;
    repeat (15) step();
    check_eq("bp_drained", n_deliv - d0 >= DEPTH, 1);

    // Flush with two responses outstanding.
    dly_min = 4; dly_max = 4;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (pend.size() == MAX_OUTST) done = 1;
    end
    check_eq("outst_reached", done, 1);
    flush_tgt = 32'h0000_2002; flush_req = 1'b1;
    step();
    step();
    #2;
    check_eq("flush_addr", mem_addr_o, 32'h0000_2000);
    check_eq("flush_valid_low", core_valid_o, 0);
    d0 = n_deliv;
    repeat (30) step();
    check_eq("flush_resumed", n_deliv - d0 > 0, 1);

    // Flush coinciding with a response.
    dly_min = 1; dly_max = 1;
    repeat (6) step();
    flush_tgt = 32'h0000_3000; flush_req = 1'b1;
    step();
    step();
    #2;
    check_eq("flush2_req", mem_req_o, 1);
    check_eq("flush2_addr", mem_addr_o, 32'h0000_3000);
    check_eq("flush2_valid_low", core_valid_o, 0);
    repeat (10) step();

    // Address wrap at the top of memory.
    flush_tgt = 32'hFFFF_FFF8; flush_req = 1'b1;
    step();
    saw_wrap = 1'b0;
    repeat (20) step();
    check_eq("pc_wrapped", saw_wrap, 1);

    // Randomized traffic.
    gnt_pct = 70; rdy_pct = 60; dly_min = 1; dly_max = 5; flush_pct = 3;
    repeat (3000) step();

    // Drain with grants stopped.
    flush_pct = 0; gnt_pct = 0; rdy_pct = 100;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (pend.size() == 0 && exp_q.size() == 0) done = 1;
    end
    check_eq("drain_complete", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
